mux_nx1_arb: RTL
================

Name: mux_nx1_arb

Overview:
- Parametrised N-input, 1-output registered multiplexer with a valid/ready handshake on every channel.
- Selection is by one of three modes: manual select (the classic select-driven mux), fixed priority, or round-robin arbitration.
- One output register stage; sits between multiple producers and a single shared consumer.

Parameters:
- N, 4, number of input channels (>= 2)
- W, 8, data width per channel
- SEL_W, $clog2(N), width of select/channel-index fields (derived; not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  2  00 manual, 01 fixed priority, 10 round-robin, 11 treated as round-robin
- sel  input  SEL_W  channel index used in manual mode
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- in_data  input  N*W  flattened data; channel i occupies bits [i*W +: W]
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready
- out_data  output  W  registered output data
- out_chan  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer=0.
  - in_ready=0 while in reset.
- Register load:
  - accept = !out_valid | out_ready.
  - When accept is high and a grant exists, the granted channel's word, index and valid=1 load on the next rising edge.
  - When accept is high and there is no grant, out_valid clears to 0.
  - When accept is low, the output register holds.
- Handshakes:
  - in_ready[i] = accept & grant[i], so at most one bit is high per cycle.
  - A transfer on channel i happens when in_valid[i] & in_ready[i].
  - The output transfers when out_valid & out_ready.
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 word/cycle when out_ready is held high.
- Grant, manual (00):
  - grant[sel]=1 only if in_valid[sel].
  - If sel >= N, no grant and no transfer.
  - Other channels stall regardless of their valid.
- Grant, fixed priority (01): lowest-index valid channel wins.
- Grant, round-robin (10/11):
  - Search starts at the pointer and wraps modulo N; the first valid channel wins.
  - On a transfer from channel g, the pointer becomes (g+1) mod N; the wrap from N-1 goes to 0.
  - The pointer does not move without a transfer, so a stalled output keeps the pending grant stable.
- Pointer in other modes: the pointer updates only on round-robin transfers and is retained across mode changes.
- Mode/sel changes: take effect on the same cycle's grant (combinational). No glitch protection is required beyond the registered output.
- Simultaneous events: out_ready with a new grant in the same cycle gives back-to-back transfer with no bubble.
- Input valid drop: inputs may deassert valid without a transfer. The bench must not flag this; the block does not require valid stickiness.
- Reset mid-operation: the pending output word is discarded and the pointer returns to 0.
- Grant generation is combinational; only out_* and the pointer are flops.

Decomposition:
- Shared package mux_arb_pkg:
  - Mode constants MODE_MANUAL=2'b00, MODE_FIXED=2'b01, MODE_RR=2'b10.
  - A function for one-hot to index conversion.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr[SEL_W], mode, sel.
  - Outputs: grant one-hot [N] and grant_idx [SEL_W].
- The top level holds the output register, the pointer flop and the handshake logic.

Test Plan:
1. Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0; release -> first grant on the next edge.
2. Manual mode, N=4, W=8, out_ready=1, data 8'h11/22/33/44, sel=2 -> out_data=8'h33, out_chan=2 one cycle later; sel=3 with in_valid[3]=0 -> out_valid=0.
3. Fixed priority, in_valid=4'b1010 -> out_chan=1 every cycle, channel 3 starved; in_valid=4'b1000 -> out_chan=3.
4. Round-robin, in_valid=4'b1111, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles; in_valid=4'b0101 -> 0,2,0,2.
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_chan stable, in_ready=0, pointer unchanged; out_ready=1 -> next word with no bubble.
6. Reset mid-stream in round-robin after a grant to channel 2 -> out_valid drops immediately (async); after release the first grant goes to channel 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-to-1 arbitrated mux: selection modes and an index helper.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_FIXED  = 2'b01,
        MODE_RR     = 2'b10,
        MODE_RR_ALT = 2'b11
    } mode_e;

    // Widest one-hot vector the index helper accepts.
    localparam int unsigned MAX_N = 32;

    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant generation for manual, fixed-priority and round-robin selection.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    localparam int unsigned SEL_SPAN = 2 ** SEL_W;

    logic [SEL_SPAN-1:0] req_ext;
    logic [SEL_SPAN-1:0] man_grant;
    logic                found;
    logic [SEL_W-1:0]    idx;

    // Widening to the full select range makes sel >= N land on dropped bits, i.e. no grant.
    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        man_grant        = '0;
        man_grant[sel]   = req_ext[sel];
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        case (mode_e'(mode))
            MODE_MANUAL: grant = man_grant[N-1:0];
            MODE_FIXED: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!found && req[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
            default: begin
                for (int unsigned i = 0; i < N; i++) begin
                    idx = SEL_W'((32'(ptr) + i) % N);
                    if (!found && req[idx]) begin
                        grant[idx] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        endcase
    end

    assign grant_idx = SEL_W'(onehot_to_idx(MAX_N'(grant)));

endmodule

// File: rtl/mux_nx1_arb.sv
// N-input registered mux with valid/ready handshakes and selectable arbitration.
module mux_nx1_arb
    import mux_arb_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned W     = 8,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan
);

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] rr_ptr;
    logic [W-1:0]     grant_data;
    logic             accept;
    logic             take;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .mode      (mode),
        .sel       (sel),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept   = !out_valid || out_ready;
    assign take     = accept && (|grant);
    assign in_ready = (accept && rst_n) ? grant : '0;

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) grant_data = grant_data | in_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                out_valid <= |grant;
                if (|grant) begin
                    out_data <= grant_data;
                    out_chan <= grant_idx;
                end
            end
            // mode[1] covers both round-robin encodings (10 and 11).
            if (take && mode[1]) begin
                rr_ptr <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule
